// File: rtl/alu_ctrl_pkg.sv
// Shared constants for the arbitrated 4-bit ALU sequencer:
// opcodes, FSM state encoding, flag bit positions and the latched request.
package alu_ctrl_pkg;

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_NOTA = 4'b0010;
    localparam logic [3:0] OP_AND  = 4'b0011;
    localparam logic [3:0] OP_OR   = 4'b0100;
    localparam logic [3:0] OP_XOR  = 4'b0101;
    localparam logic [3:0] OP_SLT  = 4'b0110;
    localparam logic [3:0] OP_EQ   = 4'b0111;
    localparam logic [3:0] OP_MUL  = 4'b1000;

    // resp_flags = {less, cout, over, zero}
    localparam int FLAG_LESS = 3;
    localparam int FLAG_COUT = 2;
    localparam int FLAG_OVER = 1;
    localparam int FLAG_ZERO = 0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    typedef struct packed {
        logic [3:0] op;
        logic [3:0] a;
        logic [3:0] b;
    } req_t;

endpackage

// File: rtl/alu4.sv
// Combinational 4-bit ALU. One shared adder serves add, sub and signed-less;
// the multiplier in the controller reuses it through the add opcode.
module alu4
    import alu_ctrl_pkg::*;
(
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic [2:0] op,
    output logic [3:0] f,
    output logic       zero,
    output logic       over,
    output logic       cout,
    output logic       less
);

    logic       inv;
    logic [3:0] xb;
    logic [4:0] sum;
    logic       ovf;
    logic       lt;

    // Adder with optional b inversion, then per-op result and flag selection
    always_comb begin
        inv  = (op == OP_SUB[2:0]) || (op == OP_SLT[2:0]);
        xb   = inv ? ~b : b;
        sum  = {1'b0, a} + {1'b0, xb} + {4'b0000, inv};
        ovf  = (a[3] == xb[3]) && (sum[3] != a[3]);
        lt   = ovf ^ sum[3];
        f    = 4'b0000;
        cout = 1'b0;
        over = 1'b0;
        less = 1'b0;
        case (op)
            OP_ADD[2:0], OP_SUB[2:0]: begin
                f    = sum[3:0];
                cout = sum[4];
                over = ovf;
            end
            OP_NOTA[2:0]: f = ~a;
            OP_AND[2:0]:  f = a & b;
            OP_OR[2:0]:   f = a | b;
            OP_XOR[2:0]:  f = a ^ b;
            OP_SLT[2:0]: begin
                f    = {3'b000, lt};
                cout = sum[4];
                over = ovf;
                less = lt;
            end
            default:      f = {3'b000, a == b};
        endcase
        // less reports the flags of its underlying subtraction
        zero = (op == OP_SLT[2:0]) ? ~|sum[3:0] : ~|f;
    end

endmodule

// File: rtl/alu_arb_seq.sv
// Two-port arbitrated ALU sequencer: IDLE -> EXEC -> RESP, one transaction
// in flight. Multiply is a 4-step shift-and-add through the alu4 adder.
module alu_arb_seq
    import alu_ctrl_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter bit RR_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       req_valid,
    output logic [1:0]       req_ready,
    input  logic [WIDTH-1:0] req_op0,
    input  logic [WIDTH-1:0] req_op1,
    input  logic [WIDTH-1:0] req_a0,
    input  logic [WIDTH-1:0] req_b0,
    input  logic [WIDTH-1:0] req_a1,
    input  logic [WIDTH-1:0] req_b1,
    output logic [1:0]       resp_valid,
    input  logic [1:0]       resp_ready,
    output logic [WIDTH-1:0] resp_f,
    output logic [3:0]       resp_flags,
    output logic             busy
);

    state_e     state, state_nxt;
    req_t       req_q, req_sel;
    logic       owner_q, last_q, gnt;
    logic [1:0] step_q;
    logic [3:0] acc_q, res_f_q, res_fl_q;
    logic       mul_c_q;
    logic       accept, resp_hs, is_mul, legal, lost, mul_c_nxt;
    logic [7:0] shifted;
    logic [3:0] alu_a, alu_b, alu_f, exec_f, exec_fl;
    logic [2:0] alu_op;
    logic       alu_z, alu_o, alu_c, alu_l;

    // Grant: on contention round-robin favours the port not served last
    always_comb begin
        if (req_valid == 2'b11) gnt = RR_EN ? ~last_q : 1'b0;
        else                    gnt = ~req_valid[0];
        req_sel = gnt ? {req_op1, req_a1, req_b1} : {req_op0, req_a0, req_b0};
    end

    assign accept  = |req_ready;
    assign resp_hs = (state == ST_RESP) && resp_ready[owner_q];

    // ALU operand steering: multiply feeds acc + (b[i] ? a<<i : 0)
    always_comb begin
        is_mul    = (req_q.op == OP_MUL);
        legal     = !req_q.op[3] || is_mul;
        shifted   = {4'b0000, req_q.a} << step_q;
        alu_a     = is_mul ? acc_q : req_q.a;
        alu_b     = is_mul ? (req_q.b[step_q] ? shifted[3:0] : 4'b0000) : req_q.b;
        alu_op    = is_mul ? OP_ADD[2:0] : req_q.op[2:0];
        lost      = is_mul && req_q.b[step_q] && |shifted[7:4];
        mul_c_nxt = mul_c_q | alu_c | lost;
        exec_f    = alu_f;
        exec_fl   = '0;
        if (is_mul) begin
            exec_fl[FLAG_COUT] = mul_c_nxt;
            exec_fl[FLAG_ZERO] = (alu_f == 4'b0000);
        end else if (legal) begin
            exec_fl[FLAG_LESS] = alu_l;
            exec_fl[FLAG_COUT] = alu_c;
            exec_fl[FLAG_OVER] = alu_o;
            exec_fl[FLAG_ZERO] = alu_z;
        end else begin
            exec_f             = 4'b0000;
            exec_fl[FLAG_ZERO] = 1'b1;
        end
    end

    alu4 u_alu (
        .a    (alu_a),
        .b    (alu_b),
        .op   (alu_op),
        .f    (alu_f),
        .zero (alu_z),
        .over (alu_o),
        .cout (alu_c),
        .less (alu_l)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    // Next state: non-mul spends one EXEC cycle, mul spends four
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (accept) state_nxt = ST_EXEC;
            ST_EXEC: if (!is_mul || step_q == 2'd3) state_nxt = ST_RESP;
            ST_RESP: if (resp_hs) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Outputs: ready only to the grantee in IDLE, response only to the owner in RESP
    always_comb begin
        req_ready  = '0;
        resp_valid = '0;
        resp_f     = '0;
        resp_flags = '0;
        busy       = (state != ST_IDLE);
        case (state)
            ST_IDLE: if (rst_n) req_ready[gnt] = req_valid[gnt];
            ST_RESP: begin
                resp_valid[owner_q] = 1'b1;
                resp_f              = res_f_q;
                resp_flags          = res_fl_q;
            end
            default: ;
        endcase
    end

    // Datapath: latch request, step multiply, register result, track last-served
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_q    <= '0;
            owner_q  <= 1'b0;
            last_q   <= 1'b1;
            step_q   <= 2'd0;
            acc_q    <= 4'b0000;
            mul_c_q  <= 1'b0;
            res_f_q  <= 4'b0000;
            res_fl_q <= 4'b0000;
        end else begin
            if (accept) begin
                req_q   <= req_sel;
                owner_q <= gnt;
                step_q  <= 2'd0;
                acc_q   <= 4'b0000;
                mul_c_q <= 1'b0;
            end
            if (state == ST_EXEC) begin
                if (is_mul) begin
                    acc_q   <= alu_f;
                    step_q  <= step_q + 2'd1;
                    mul_c_q <= mul_c_nxt;
                end
                if (!is_mul || step_q == 2'd3) begin
                    res_f_q  <= exec_f;
                    res_fl_q <= exec_fl;
                end
            end
            if (resp_hs) last_q <= owner_q;
        end
    end

endmodule

// File: tb/tb_alu_arb_seq.sv
// Bench for alu_arb_seq: a round-robin and a fixed-priority instance share
// stimulus; each is checked every cycle against a transaction-level model.
module tb_alu_arb_seq;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] req_valid = '0, resp_ready = '0;
    logic [3:0] req_op0 = '0, req_op1 = '0, req_a0 = '0, req_b0 = '0, req_a1 = '0, req_b1 = '0;
    logic [1:0] rdy_o[2], rv_o[2];
    logic [3:0] f_o[2], fl_o[2];
    logic       busy_o[2];

    int n_chk = 0, n_fail = 0;

    // model state per instance (0 = round-robin, 1 = fixed priority)
    int         ph[2];   // 0 idle, 1 exec, 2 resp
    int         cnt[2];
    logic       own[2], last[2];
    logic [7:0] exp_r[2];

    always #5 clk = ~clk;

    alu_arb_seq #(.WIDTH(4), .RR_EN(1'b1)) u_rr (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(rdy_o[0]),
        .req_op0(req_op0), .req_op1(req_op1), .req_a0(req_a0), .req_b0(req_b0),
        .req_a1(req_a1), .req_b1(req_b1), .resp_valid(rv_o[0]), .resp_ready(resp_ready),
        .resp_f(f_o[0]), .resp_flags(fl_o[0]), .busy(busy_o[0])
    );

    alu_arb_seq #(.WIDTH(4), .RR_EN(1'b0)) u_fp (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(rdy_o[1]),
        .req_op0(req_op0), .req_op1(req_op1), .req_a0(req_a0), .req_b0(req_b0),
        .req_a1(req_a1), .req_b1(req_b1), .resp_valid(rv_o[1]), .resp_ready(resp_ready),
        .resp_f(f_o[1]), .resp_flags(fl_o[1]), .busy(busy_o[1])
    );

    task automatic chk(input string tag, input logic [3:0] got, input logic [3:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%b exp=%b t=%0t", tag, got, exp, $time);
        end
    endtask

    // Reference result {less,cout,over,zero, f} from plain arithmetic
    function automatic logic [7:0] ref_alu(input logic [3:0] op, input logic [3:0] a, input logic [3:0] b);
        int ua, ub, sa, sb, r, p;
        logic [3:0] f, fl;
        ua = int'(a); ub = int'(b);
        sa = a[3] ? ua - 16 : ua;
        sb = b[3] ? ub - 16 : ub;
        fl = 4'b0000;
        case (op)
            4'd0: begin
                r = sa + sb; f = 4'((ua + ub) % 16);
                fl = {1'b0, (ua + ub) > 15, (r > 7 || r < -8), f == 4'd0};
            end
            4'd1: begin
                r = sa - sb; f = 4'((ua - ub + 16) % 16);
                fl = {1'b0, ua >= ub, (r > 7 || r < -8), f == 4'd0};
            end
            4'd2: begin f = ~a;    fl = {3'b000, f == 4'd0}; end
            4'd3: begin f = a & b; fl = {3'b000, f == 4'd0}; end
            4'd4: begin f = a | b; fl = {3'b000, f == 4'd0}; end
            4'd5: begin f = a ^ b; fl = {3'b000, f == 4'd0}; end
            4'd6: begin
                r = sa - sb; f = {3'b000, sa < sb};
                fl = {sa < sb, ua >= ub, (r > 7 || r < -8), ua == ub};
            end
            4'd7: begin f = {3'b000, a == b}; fl = {3'b000, f == 4'd0}; end
            4'd8: begin
                p = ua * ub; f = 4'(p % 16);
                fl = {1'b0, p > 15, 1'b0, f == 4'd0};
            end
            default: begin f = 4'd0; fl = 4'b0001; end
        endcase
        return {fl, f};
    endfunction

    function automatic logic grant(input int k, input logic [1:0] v);
        if (v == 2'b11) return (k == 0) ? !last[k] : 1'b0;
        return v[0] ? 1'b0 : 1'b1;
    endfunction

    // One clock: drive at negedge, check 1ns later, advance model at posedge
    task automatic step(input logic [1:0] v, input logic [1:0] rr,
                        input logic [3:0] o0, input logic [3:0] a0, input logic [3:0] b0,
                        input logic [3:0] o1, input logic [3:0] a1, input logic [3:0] b1,
                        input bit rst);
        logic       g;
        logic [1:0] er, ev;
        logic       eb;
        logic [7:0] eo;
        @(negedge clk);
        rst_n = !rst; req_valid = v; resp_ready = rr;
        req_op0 = o0; req_a0 = a0; req_b0 = b0;
        req_op1 = o1; req_a1 = a1; req_b1 = b1;
        #1;
        for (int k = 0; k < 2; k++) begin
            g = grant(k, v);
            er = '0; ev = '0; eb = 1'b0; eo = '0;
            if (!rst) begin
                case (ph[k])
                    0: if (v != 2'b00) er[g] = 1'b1;
                    1: eb = 1'b1;
                    default: begin eb = 1'b1; ev[own[k]] = 1'b1; eo = exp_r[k]; end
                endcase
            end
            chk($sformatf("req_ready[%0d]", k), {2'b00, rdy_o[k]}, {2'b00, er});
            chk($sformatf("resp_valid[%0d]", k), {2'b00, rv_o[k]}, {2'b00, ev});
            chk($sformatf("resp_f[%0d]", k), f_o[k], eo[3:0]);
            chk($sformatf("resp_flags[%0d]", k), fl_o[k], eo[7:4]);
            chk($sformatf("busy[%0d]", k), {3'b000, busy_o[k]}, {3'b000, eb});
        end
        @(posedge clk);
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                ph[k] = 0; last[k] = 1'b1;
            end else begin
                case (ph[k])
                    0: if (v != 2'b00) begin
                        g = grant(k, v);
                        own[k] = g;
                        exp_r[k] = g ? ref_alu(o1, a1, b1) : ref_alu(o0, a0, b0);
                        cnt[k] = ((g ? o1 : o0) == 4'd8) ? 4 : 1;
                        ph[k] = 1;
                    end
                    1: begin cnt[k]--; if (cnt[k] == 0) ph[k] = 2; end
                    default: if (rr[own[k]]) begin ph[k] = 0; last[k] = own[k]; end
                endcase
            end
        end
    endtask

    task automatic idle(input int n, input logic [1:0] rr);
        for (int i = 0; i < n; i++) step(2'b00, rr, 0, 0, 0, 0, 0, 0, 1'b0);
    endtask

    initial begin
        logic [1:0] v, rr;
        logic [3:0] o0, o1;
        bit         rst;
        for (int k = 0; k < 2; k++) begin ph[k] = 0; cnt[k] = 0; own[k] = 0; last[k] = 1; exp_r[k] = 0; end

        // reset state
        step(2'b11, 2'b11, 0, 1, 1, 0, 1, 1, 1'b1);
        step(2'b00, 2'b11, 0, 0, 0, 0, 0, 0, 1'b1);
        // add 7+1 on port 0
        step(2'b01, 2'b11, 4'd0, 4'd7, 4'd1, 0, 0, 0, 1'b0);
        idle(3, 2'b11);
        // mul 5*3 and 6*3 on port 1
        step(2'b10, 2'b11, 0, 0, 0, 4'd8, 4'd5, 4'd3, 1'b0);
        idle(6, 2'b11);
        step(2'b10, 2'b11, 0, 0, 0, 4'd8, 4'd6, 4'd3, 1'b0);
        idle(6, 2'b11);
        // less 1000 vs 0111, sub 0-1, illegal 1111
        step(2'b01, 2'b11, 4'd6, 4'b1000, 4'b0111, 0, 0, 0, 1'b0);
        idle(3, 2'b11);
        step(2'b01, 2'b11, 4'd1, 4'd0, 4'd1, 0, 0, 0, 1'b0);
        idle(3, 2'b11);
        step(2'b01, 2'b11, 4'hf, 4'd9, 4'd9, 0, 0, 0, 1'b0);
        idle(3, 2'b11);
        // response held off while both ports keep requesting
        step(2'b10, 2'b00, 0, 0, 0, 4'd5, 4'd12, 4'd10, 1'b0);
        for (int i = 0; i < 7; i++) step(2'b11, 2'b00, 4'd0, 4'd1, 4'd2, 4'd0, 4'd3, 4'd4, 1'b0);
        // continuous contention: rr alternates, fixed priority sticks to port 0
        for (int i = 0; i < 12; i++) step(2'b11, 2'b11, 4'd0, 4'(i), 4'd1, 4'd3, 4'(i), 4'd7, 1'b0);
        idle(3, 2'b11);
        // reset during multiply step 2, then the still-pending port 1 is re-granted
        step(2'b10, 2'b11, 0, 0, 0, 4'd8, 4'd7, 4'd7, 1'b0);
        step(2'b10, 2'b11, 0, 0, 0, 4'd8, 4'd7, 4'd7, 1'b0);
        step(2'b10, 2'b11, 0, 0, 0, 4'd8, 4'd7, 4'd7, 1'b0);
        step(2'b10, 2'b11, 0, 0, 0, 4'd8, 4'd7, 4'd7, 1'b1);
        for (int i = 0; i < 8; i++) step(2'b10, 2'b11, 0, 0, 0, 4'd8, 4'd7, 4'd7, 1'b0);
        idle(3, 2'b11);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            v   = 2'($urandom_range(0, 3));
            rr  = ($urandom_range(0, 2) == 0) ? 2'($urandom_range(0, 3)) : 2'b11;
            o0  = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(9, 15)) : 4'($urandom_range(0, 8));
            o1  = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(9, 15)) : 4'($urandom_range(0, 8));
            rst = ($urandom_range(0, 199) == 0);
            step(v, rr, o0, 4'($urandom), 4'($urandom), o1, 4'($urandom), 4'($urandom), rst);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_arb_seq.md
ALU_ARB_SEQ -- requirements
Module: alu_arb_seq

Interface
REQ-001 SHALL have parameter: WIDTH, 4, operand/result width; only 4 is supported.
REQ-002 SHALL have parameter: RR_EN, 1, 1 = round-robin arbitration, 0 = fixed priority to port 0.
REQ-003 SHALL have port: clk  in  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port: rst_n  in  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have ports: req_valid[1:0]  in  2  per-port request valid.
REQ-006 SHALL have ports: req_ready[1:0]  out  2  per-port request accept.
REQ-007 SHALL have ports: req_op0, req_op1  in  4 each  opcode; 0000 add, 0001 sub, 0010 not-a, 0011 and, 0100 or, 0101 xor, 0110 signed less, 0111 equal, 1000 mul; others illegal.
REQ-008 SHALL have ports: req_a0, req_b0, req_a1, req_b1  in  4 each  operands.
REQ-009 SHALL have ports: resp_valid[1:0]  out  2  per-port response valid.
REQ-010 SHALL have ports: resp_ready[1:0]  in  2  per-port response accept.
REQ-011 SHALL have ports: resp_f  out  4  result, shared by both ports.
REQ-012 SHALL have ports: resp_flags  out  4  {less, cout, over, zero}, shared.
REQ-013 SHALL have port: busy  out  1  high in any state other than IDLE.

Function
REQ-014 SHALL implement FSM IDLE -> EXEC -> RESP -> IDLE; one transaction in flight.
REQ-015 In IDLE, SHALL assert req_ready only to the granted port, combinationally; req_ready SHALL be 0 in EXEC and RESP.
REQ-016 Grant, RR_EN=1: with both ports valid, the port not served last wins; the last-served pointer resets to port 1, so port 0 wins first.
REQ-017 Grant, RR_EN=0: port 0 wins whenever req_valid[0]=1.
REQ-018 On acceptance (valid&ready) SHALL latch op, a, b and owner, then go to EXEC next cycle.
REQ-019 Non-mul ops SHALL spend exactly 1 EXEC cycle, register the sub-module result and flags, then enter RESP.
- resp_valid rises 2 cycles after the accept edge.
REQ-020 Mul SHALL spend exactly 4 EXEC cycles, counting step i = 0..3.
- Each step: acc <= acc + (b[i] ? a<<i : 0) mod 16, using the sub-module add.
- acc SHALL be cleared at accept.
REQ-021 Mul flags:
- zero = (final acc == 0).
- cout = 1 if any step carried out or any set bit of a was shifted beyond bit 3 under a set b[i] (i.e. true product > 15).
- over = 0, less = 0.
REQ-022 Add/sub flags SHALL follow two's-complement rules:
- sub is a + ~b + 1, and cout is the raw carry-out.
- over = (a[3]==xb[3]) && (f[3]!=a[3]).
- zero = ~|f.
REQ-023 Less (0110) SHALL give f = {3'b0, less} with less = over ^ diff[3]; flags from the subtraction. Equal (0111) SHALL give f = {3'b0, a==b}.
REQ-024 Logic ops SHALL give cout = over = less = 0 and zero = ~|f.
REQ-025 Illegal opcodes SHALL complete in 1 EXEC cycle with f = 0 and flags = 4'b0001.
REQ-026 In RESP, SHALL assert resp_valid only for the owner and hold resp_f/resp_flags stable until resp_ready of that port.
- On handshake: go to IDLE and update the last-served pointer.
- resp_ready of the non-owner SHALL be ignored.
REQ-027 A new request SHALL NOT be accepted in the same cycle as a response handshake; the earliest next accept is the following IDLE cycle.
REQ-028 resp_f and resp_flags SHALL be 0 outside RESP.

Reset
REQ-029 While rst_n=0, and immediately on its assertion, the block SHALL:
- go to IDLE; zero the step counter, acc, latched operands and registered result;
- set the pointer to port 1;
- drive req_ready, resp_valid, resp_f, resp_flags and busy to 0.
REQ-030 Reset during EXEC or RESP SHALL abort the transaction; no response is ever issued for it.

Structure
REQ-031 Opcode constants, state encodings and flag bit positions SHALL live in shared package alu_ctrl_pkg.
REQ-032 Combinational datapath SHALL be one sub-module alu4 (a, b, op[2:0] -> f, zero, over, cout, less); the controller SHALL contain no duplicate adder.

Verification
REQ-033 Port 0: add a=7, b=1 -> resp_valid[0] 2 cycles after accept; f=8, flags={0,0,1,0}.
REQ-034 Port 1: mul a=5, b=3 -> resp_valid[1] 5 cycles after accept; f=15, cout=0. Then mul a=6, b=3 -> f=2, cout=1.
REQ-035 Both ports valid continuously with RR_EN=1 -> grants alternate 0,1,0,1. With RR_EN=0 -> port 0 every time.
REQ-036 resp_ready held 0 for 5 cycles in RESP -> outputs stable; req_ready stays 0; no second accept.
REQ-037 rst_n pulsed low mid-mul (step 2) -> all outputs 0 immediately; after release the pending port is re-granted, and no stale response appears.
REQ-038 Less a=4'b1000, b=4'b0111 -> f=1. Sub a=0, b=1 -> f=15, cout=0, zero=0. Opcode 1111 -> f=0, flags=0001.
